// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the memory stage and dmem_resp.
//   dce    : request valid                 stall  : hold the pipeline (combinational)
//   daddr  : byte address                  dout   : read word, raw lanes (registered)
//   dre    : byte-lane read enables        dvalid : one-cycle response strobe
//   we     : byte-lane write enables       derr   : response error, qualified by dvalid
//   din    : lane-placed store data
// Lane k carries byte offset 3-k (lane 3 is offset 0).
interface dmem_if;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  dre;
  logic [3:0]  we;
  logic [31:0] din;
  logic        stall;
  logic [31:0] dout;
  logic        dvalid;
  logic        derr;

  modport master (
    output dce, daddr, dre, we, din,
    input  stall, dout, dvalid, derr
  );

  modport slave (
    input  dce, daddr, dre, we, din,
    output stall, dout, dvalid, derr
  );
endinterface

// File: rtl/dmem_resp.sv
// Wait-stated data memory responder: a 2^ADDR_W x 32-bit RAM behind a fixed-latency
// request/response handshake. A request accepted in cycle C stalls the pipeline for
// WAIT cycles, touches the RAM in cycle C+WAIT and answers with a dvalid pulse in C+WAIT+1.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (RAM contents are kept)
//   bus   : dmem_if slave side (dce/daddr/dre/we/din in, stall/dout/dvalid/derr out)
// Parameters:
//   ADDR_W : word-address width
//   WAIT   : wait states per access, 0..7
module dmem_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int unsigned Words    = 1 << ADDR_W;
  localparam bit          ZeroWait = (WAIT == 0);
  localparam bit          OneWait  = (WAIT == 1);
  localparam logic [2:0]  WaitM1   = 3'(WAIT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAccess} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  // Request copy taken at accept; the live inputs are not looked at afterwards.
  logic [31:0] addr_q, din_q;
  logic [3:0]  dre_q, we_q;
  logic        latch_en;

  logic        acc_en;    // RAM access happens this cycle
  logic        sel_live;  // zero-wait access uses the live request inputs
  logic [31:0] acc_addr, acc_din;
  logic [3:0]  acc_dre, acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic        lane_ok, range_err, we_err, acc_err, wr_en;
  logic [31:0] old_word, new_word;

  logic [31:0] mem [Words];

  logic [31:0] dout_q;
  logic        dvalid_q, derr_q;
  logic        stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    latch_en = 1'b0;
    acc_en   = 1'b0;
    sel_live = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.dce) begin
          if (ZeroWait) begin
            acc_en   = 1'b1;
            sel_live = 1'b1;
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            cnt_d    = WaitM1;
            state_d  = OneWait ? StAccess : StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StAccess;
      end
      StAccess: begin
        // dce is deliberately not sampled here; the next request waits one cycle.
        acc_en  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset both drops the hold request and suppresses any RAM write this cycle.
    if (!rst_n) begin
      stall  = 1'b0;
      acc_en = 1'b0;
    end
  end

  assign acc_addr = sel_live ? bus.daddr : addr_q;
  assign acc_dre  = sel_live ? bus.dre   : dre_q;
  assign acc_we   = sel_live ? bus.we    : we_q;
  assign acc_din  = sel_live ? bus.din   : din_q;
  assign acc_idx  = acc_addr[ADDR_W+1:2];

  // A single-lane enable must name the byte that daddr[1:0] points at.
  always_comb begin
    lane_ok = 1'b0;
    case (acc_dre)
      4'b0001: lane_ok = (acc_addr[1:0] == 2'd3);
      4'b0010: lane_ok = (acc_addr[1:0] == 2'd2);
      4'b0100: lane_ok = (acc_addr[1:0] == 2'd1);
      4'b1000: lane_ok = (acc_addr[1:0] == 2'd0);
      4'b1111: lane_ok = (acc_addr[1:0] == 2'd0);
      default: lane_ok = 1'b0;
    endcase
  end

  assign range_err = ((acc_addr >> (ADDR_W + 2)) != 32'd0);
  assign we_err    = (acc_we != 4'd0) && (acc_we != acc_dre);
  assign acc_err   = !lane_ok || range_err || we_err;

  assign old_word = mem[acc_idx];

  // Write-first merge: the read word already reflects this access's store lanes.
  always_comb begin
    new_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (acc_we[k]) new_word[8*k +: 8] = acc_din[8*k +: 8];
    end
  end

  assign wr_en = acc_en && !acc_err && (acc_we != 4'd0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[acc_idx] <= new_word;
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      addr_q <= bus.daddr;
      dre_q  <= bus.dre;
      we_q   <= bus.we;
      din_q  <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      dout_q   <= 32'd0;
      dvalid_q <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvalid_q <= acc_en;
      derr_q   <= acc_en && acc_err;
      if (acc_en) dout_q <= acc_err ? 32'd0 : new_word;
    end
  end

  assign bus.stall  = stall;
  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.derr   = derr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances (WAIT = 0, 2, 3) with a byte-array
// reference model for the WAIT = 2 randomized phase.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_n0, rst_n2, rst_n3;

  dmem_if if0 ();
  dmem_if if2 ();
  dmem_if if3 ();

  dmem_resp #(.ADDR_W(10), .WAIT(0)) u_w0 (.clk(clk), .rst_n(rst_n0), .bus(if0));
  dmem_resp #(.ADDR_W(10), .WAIT(2)) u_w2 (.clk(clk), .rst_n(rst_n2), .bus(if2));
  dmem_resp #(.ADDR_W(10), .WAIT(3)) u_w3 (.clk(clk), .rst_n(rst_n3), .bus(if3));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Byte-addressed model of the WAIT=2 RAM; offset 0 is the most significant byte.
  logic [7:0] mb [4096];

  typedef struct {
    logic [31:0] a;
    logic [3:0]  r;
    logic [3:0]  wm;
    logic [31:0] d;
    logic [31:0] exp;
    logic        err;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic c, input logic [31:0] a,
                         input logic [3:0] r, input logic [3:0] wm, input logic [31:0] d);
    case (idx)
      0: begin if0.dce = c; if0.daddr = a; if0.dre = r; if0.we = wm; if0.din = d; end
      2: begin if2.dce = c; if2.daddr = a; if2.dre = r; if2.we = wm; if2.din = d; end
      default: begin if3.dce = c; if3.daddr = a; if3.dre = r; if3.we = wm; if3.din = d; end
    endcase
  endtask

  task automatic get_out(input int idx, output logic s, output logic [31:0] o,
                         output logic v, output logic e);
    case (idx)
      0: begin s = if0.stall; o = if0.dout; v = if0.dvalid; e = if0.derr; end
      2: begin s = if2.stall; o = if2.dout; v = if2.dvalid; e = if2.derr; end
      default: begin s = if3.stall; o = if3.dout; v = if3.dvalid; e = if3.derr; end
    endcase
  endtask

  function automatic logic [31:0] model_acc(input logic [31:0] a, input logic [3:0] r,
                                            input logic [3:0] wm, input logic [31:0] d,
                                            output logic err);
    int unsigned off;
    int unsigned base;
    off = a % 4;
    base = a - off;
    err = 1'b0;
    if (a >= 32'h1000) err = 1'b1;
    else if (wm != 4'd0 && wm != r) err = 1'b1;
    else if (r == 4'hF) err = (off != 0);
    else if ($countones(r) != 1) err = 1'b1;
    else begin
      for (int k = 0; k < 4; k++) if (r[k] && (3 - k) != int'(off)) err = 1'b1;
    end
    if (err) return 32'd0;
    for (int o = 0; o < 4; o++) begin
      if (wm[3-o]) mb[base+o] = d[8*(3-o) +: 8];
    end
    return {mb[base], mb[base+1], mb[base+2], mb[base+3]};
  endfunction

  // One request from accept through the response cycle. Caller aligns to a negedge.
  task automatic txn(input int idx, input int w, input logic [31:0] a, input logic [3:0] r,
                     input logic [3:0] wm, input logic [31:0] d, input logic [31:0] exp_dout,
                     input logic exp_err, input bit hold, input string tag);
    logic s, v, e;
    logic [31:0] o;
    set_req(idx, 1'b1, a, r, wm, d);
    #1 get_out(idx, s, o, v, e);
    chk({tag, " stall@accept"}, 32'(s), 32'(w > 0));
    chk({tag, " dvalid@accept"}, 32'(v), 32'd0);
    for (int i = 1; i <= w; i++) begin
      @(negedge clk);
      if (i == w && !hold) set_req(idx, 1'b0, a, r, wm, d);
      #1 get_out(idx, s, o, v, e);
      chk({tag, " stall@wait"}, 32'(s), 32'(i < w));
      chk({tag, " dvalid@wait"}, 32'(v), 32'd0);
    end
    @(negedge clk);
    set_req(idx, 1'b0, a, r, wm, d);
    #1 get_out(idx, s, o, v, e);
    chk({tag, " dvalid"}, 32'(v), 32'd1);
    chk({tag, " derr"}, 32'(e), 32'(exp_err));
    chk({tag, " dout"}, o, exp_dout);
    if (hold) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #1 get_out(idx, s, o, v, e);
        chk({tag, " no 2nd dvalid"}, 32'(v), 32'd0);
        chk({tag, " no 2nd stall"}, 32'(s), 32'd0);
        chk({tag, " dout held"}, o, exp_dout);
      end
    end
  endtask

  initial begin
    logic s, v, e, er;
    logic [31:0] o, exp, a, d;
    logic [3:0] r, wm;
    int sel;

    // Reset with dce asserted: everything quiet.
    rst_n0 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
    set_req(0, 1'b1, 32'h0, 4'hF, 4'hF, 32'h1);
    set_req(2, 1'b1, 32'h0, 4'hF, 4'hF, 32'h1);
    set_req(3, 1'b1, 32'h0, 4'hF, 4'hF, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int idx = 0; idx <= 3; idx++) begin
      if (idx == 1) continue;
      get_out(idx, s, o, v, e);
      chk($sformatf("rst%0d stall", idx), 32'(s), 32'd0);
      chk($sformatf("rst%0d dvalid", idx), 32'(v), 32'd0);
      chk($sformatf("rst%0d derr", idx), 32'(e), 32'd0);
      chk($sformatf("rst%0d dout", idx), o, 32'd0);
      set_req(idx, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    end
    @(negedge clk);
    rst_n0 = 1'b1; rst_n2 = 1'b1; rst_n3 = 1'b1;

    // Directed vectors on the WAIT=2 instance.
    tbl.push_back('{32'h10, 4'hF, 4'hF, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, "sw 10"});
    tbl.push_back('{32'h11, 4'h4, 4'h4, 32'h11111111, 32'hAA11CCDD, 1'b0, "sb 11"});
    tbl.push_back('{32'h11, 4'h4, 4'h0, 32'h0,        32'hAA11CCDD, 1'b0, "lb 11"});
    tbl.push_back('{32'h12, 4'hF, 4'h0, 32'h0,        32'h0,        1'b1, "lw 12 misalign"});
    tbl.push_back('{32'h10, 4'hF, 4'h0, 32'h0,        32'hAA11CCDD, 1'b0, "lw 10"});
    tbl.push_back('{32'h1000, 4'hF, 4'h0, 32'h0,      32'h0,        1'b1, "lw 1000 range"});
    tbl.push_back('{32'h12, 4'hF, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, "sw 12 misalign"});
    tbl.push_back('{32'h10, 4'h8, 4'h4, 32'hFFFFFFFF, 32'h0,        1'b1, "sb we!=dre"});
    tbl.push_back('{32'h10, 4'h0, 4'h0, 32'h0,        32'h0,        1'b1, "dre zero"});
    tbl.push_back('{32'h12, 4'h3, 4'h0, 32'h0,        32'h0,        1'b1, "dre 0011"});
    tbl.push_back('{32'h13, 4'h8, 4'h0, 32'h0,        32'h0,        1'b1, "lb lane mismatch"});
    tbl.push_back('{32'h13, 4'h1, 4'h1, 32'h000000EE, 32'hAA11CCEE, 1'b0, "sb 13"});
    tbl.push_back('{32'h10, 4'h8, 4'h0, 32'h0,        32'hAA11CCEE, 1'b0, "lb 10"});
    tbl.push_back('{32'h80000010, 4'hF, 4'hF, 32'h0,  32'h0,        1'b1, "sw high addr"});
    tbl.push_back('{32'h10, 4'hF, 4'h0, 32'h0,        32'hAA11CCEE, 1'b0, "lw 10 final"});
    foreach (tbl[i]) begin
      exp = model_acc(tbl[i].a, tbl[i].r, tbl[i].wm, tbl[i].d, er);
      @(negedge clk);
      txn(2, 2, tbl[i].a, tbl[i].r, tbl[i].wm, tbl[i].d, tbl[i].exp, tbl[i].err, 1'b0,
          tbl[i].nm);
    end

    // dce held through ACCESS: one response only.
    exp = model_acc(32'h14, 4'hF, 4'hF, 32'h5A5A0F0F, er);
    @(negedge clk);
    txn(2, 2, 32'h14, 4'hF, 4'hF, 32'h5A5A0F0F, exp, er, 1'b1, "w2 hold");

    // Randomized phase against the byte model: initialise words 0..15, then mix.
    for (int n = 0; n < 16; n++) begin
      d = $urandom;
      exp = model_acc(32'(n * 4), 4'hF, 4'hF, d, er);
      @(negedge clk);
      txn(2, 2, 32'(n * 4), 4'hF, 4'hF, d, exp, er, 1'b0, $sformatf("init %0d", n));
    end
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      if (sel < 4) r = 4'(1 << sel);
      else if (sel == 4) r = 4'hF;
      else r = 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sel < 4) a[1:0] = 2'(3 - sel);
        else a[1:0] = 2'd0;
      end
      if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      case ($urandom_range(0, 3))
        0: wm = 4'h0;
        3: wm = 4'($urandom);
        default: wm = r;
      endcase
      d = $urandom;
      exp = model_acc(a, r, wm, d, er);
      @(negedge clk);
      txn(2, 2, a, r, wm, d, exp, er, 1'b0, $sformatf("rnd %0d", n));
    end

    // WAIT=0: alternating sw/lw every cycle, no stall, dvalid every cycle.
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      set_req(0, 1'b1, 32'(4 * (j / 2)), 4'hF, (j % 2 == 0) ? 4'hF : 4'h0,
              32'hC0DE0000 + 32'(j / 2));
      #1 get_out(0, s, o, v, e);
      chk($sformatf("w0 b2b stall %0d", j), 32'(s), 32'd0);
      if (j > 0) begin
        chk($sformatf("w0 b2b dvalid %0d", j), 32'(v), 32'd1);
        chk($sformatf("w0 b2b derr %0d", j), 32'(e), 32'd0);
        chk($sformatf("w0 b2b dout %0d", j), o, 32'hC0DE0000 + 32'((j - 1) / 2));
      end
    end
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    #1 get_out(0, s, o, v, e);
    chk("w0 b2b last dvalid", 32'(v), 32'd1);
    chk("w0 b2b last dout", o, 32'hC0DE0007);
    @(negedge clk);
    #1 get_out(0, s, o, v, e);
    chk("w0 b2b idle dvalid", 32'(v), 32'd0);

    // WAIT=0: reset in the accept cycle suppresses the store.
    @(negedge clk);
    rst_n0 = 1'b0;
    set_req(0, 1'b1, 32'h0, 4'hF, 4'hF, 32'hFFFFFFFF);
    #1 get_out(0, s, o, v, e);
    chk("w0 rst stall", 32'(s), 32'd0);
    @(negedge clk);
    rst_n0 = 1'b1;
    set_req(0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    #1 get_out(0, s, o, v, e);
    chk("w0 rst dvalid", 32'(v), 32'd0);
    @(negedge clk);
    txn(0, 0, 32'h0, 4'hF, 4'h0, 32'h0, 32'hC0DE0000, 1'b0, 1'b0, "w0 lw after rst");

    // WAIT=3: reset in the second stall cycle aborts the store.
    @(negedge clk);
    txn(3, 3, 32'h20, 4'hF, 4'hF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, "w3 sw init");
    @(negedge clk);
    set_req(3, 1'b1, 32'h20, 4'hF, 4'hF, 32'hDEADBEEF);
    #1 get_out(3, s, o, v, e);
    chk("w3 abort stall C", 32'(s), 32'd1);
    @(negedge clk);
    rst_n3 = 1'b0;
    #1 get_out(3, s, o, v, e);
    chk("w3 stall in rst", 32'(s), 32'd0);
    @(negedge clk);
    rst_n3 = 1'b1;
    set_req(3, 1'b0, 32'h20, 4'hF, 4'hF, 32'hDEADBEEF);
    #1 get_out(3, s, o, v, e);
    chk("w3 dout after rst", o, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("w3 aborted dvalid %0d", i), 32'(v), 32'd0);
      @(negedge clk);
      #1 get_out(3, s, o, v, e);
    end
    txn(3, 3, 32'h20, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b0, "w3 lw after abort");

    // WAIT=3: request in the first cycle after reset, dce held through ACCESS.
    @(negedge clk);
    rst_n3 = 1'b0;
    @(negedge clk);
    rst_n3 = 1'b1;
    txn(3, 3, 32'h21, 4'h4, 4'h4, 32'h00990000, 32'h12995678, 1'b0, 1'b1, "w3 sb post-rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
